// File: rtl/match_req_dispatcher_pkg.sv
// Shared types and defaults for the match-request dispatcher.
//   state_t      : dispatcher FSM states
//   DEF_*        : default geometry and channel windows (ch0 in the LSBs)
//   slot_w()     : width of a slot index, never narrower than one bit
package match_req_dispatcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_REPORT   = 2'd2
  } state_t;

  localparam int DEF_LAZY_LEN    = 4;
  localparam int DEF_NUM_CH      = 4;
  localparam int DEF_OFFSET_BITS = 20;
  localparam int DEF_INFO_BITS   = 32;

  localparam int ROUTE_FIRST = 1;

  // Windows are OFFSET_BITS+1 wide so an upper bound of 2^OFFSET_BITS fits.
  localparam logic [83:0] DEF_CH_LO = {21'd65536, 21'd0, 21'd0, 21'd0};
  localparam logic [83:0] DEF_CH_HI = {21'd1048576, 21'd65536, 21'd32768, 21'd4096};

  function automatic int slot_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/match_req_dispatcher_if.sv
// Bundle between the lazy-match front end, the dispatcher and the match PEs.
//   in_valid/in_ready/in_offset/in_info : one batch of LAZY_LEN requests
//   out_valid/out_ready                 : per-channel request handshake
//   out_offset/out_info/out_slot        : request presented on each channel
//   done_valid/done_nomatch             : end-of-batch pulse and unroutable slots
// master = environment side (front end + PEs), slave = dispatcher.
interface match_req_dispatcher_if
  import match_req_dispatcher_pkg::*;
#(
  parameter int LAZY_LEN    = DEF_LAZY_LEN,
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int OFFSET_BITS = DEF_OFFSET_BITS,
  parameter int INFO_BITS   = DEF_INFO_BITS
);
  localparam int SLOT_W = slot_w(LAZY_LEN);

  logic                            in_valid;
  logic                            in_ready;
  logic [LAZY_LEN*OFFSET_BITS-1:0] in_offset;
  logic [LAZY_LEN*INFO_BITS-1:0]   in_info;
  logic [NUM_CH-1:0]               out_valid;
  logic [NUM_CH-1:0]               out_ready;
  logic [NUM_CH*OFFSET_BITS-1:0]   out_offset;
  logic [NUM_CH*INFO_BITS-1:0]     out_info;
  logic [NUM_CH*SLOT_W-1:0]        out_slot;
  logic                            done_valid;
  logic [LAZY_LEN-1:0]             done_nomatch;

  modport master (
    output in_valid, in_offset, in_info, out_ready,
    input  in_ready, out_valid, out_offset, out_info, out_slot, done_valid, done_nomatch
  );

  modport slave (
    input  in_valid, in_offset, in_info, out_ready,
    output in_ready, out_valid, out_offset, out_info, out_slot, done_valid, done_nomatch
  );

endinterface

// File: rtl/match_req_window_cmp.sv
// Combinational route table: LAZY_LEN x NUM_CH window hit matrix.
//   offset : packed slot offsets, slot i at [i*OFFSET_BITS +: OFFSET_BITS]
//   hit    : bit i*NUM_CH+j set when slot i falls in [CH_LO[j], CH_HI[j])
// With ROUTE_MODE = ROUTE_FIRST only the lowest hitting channel is kept per slot.
module match_req_window_cmp
  import match_req_dispatcher_pkg::*;
#(
  parameter int LAZY_LEN    = DEF_LAZY_LEN,
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int OFFSET_BITS = DEF_OFFSET_BITS,
  parameter int ROUTE_MODE  = 0,
  parameter logic [NUM_CH*(OFFSET_BITS+1)-1:0] CH_LO = '0,
  parameter logic [NUM_CH*(OFFSET_BITS+1)-1:0] CH_HI = '0
) (
  input  logic [LAZY_LEN*OFFSET_BITS-1:0] offset,
  output logic [LAZY_LEN*NUM_CH-1:0]      hit
);
  localparam int BW = OFFSET_BITS + 1;

  logic [NUM_CH-1:0] row;
  logic [BW-1:0]     off_ext;

  always_comb begin
    hit     = '0;
    row     = '0;
    off_ext = '0;
    for (int i = 0; i < LAZY_LEN; i++) begin
      off_ext = {1'b0, offset[i*OFFSET_BITS +: OFFSET_BITS]};
      for (int j = 0; j < NUM_CH; j++) begin
        row[j] = (off_ext >= CH_LO[j*BW +: BW]) && (off_ext < CH_HI[j*BW +: BW]);
      end
      // x & -x isolates the lowest set bit, i.e. the lowest-index channel.
      if (ROUTE_MODE == ROUTE_FIRST) row = row & (~row + NUM_CH'(1));
      hit[i*NUM_CH +: NUM_CH] = row;
    end
  end

endmodule

// File: rtl/match_req_dispatcher.sv
// Registered, handshaked offset->channel dispatcher.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of match_req_dispatcher_if
// A batch is latched in IDLE; in DISPATCH every channel independently presents
// its lowest pending slot until the pending bitmap drains; REPORT pulses
// done_valid with the slots that matched no channel.
module match_req_dispatcher
  import match_req_dispatcher_pkg::*;
#(
  parameter int LAZY_LEN    = DEF_LAZY_LEN,
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int OFFSET_BITS = DEF_OFFSET_BITS,
  parameter int INFO_BITS   = DEF_INFO_BITS,
  parameter int ROUTE_MODE  = 0,
  parameter logic [NUM_CH*(OFFSET_BITS+1)-1:0] CH_LO = DEF_CH_LO,
  parameter logic [NUM_CH*(OFFSET_BITS+1)-1:0] CH_HI = DEF_CH_HI
) (
  input logic                   clk,
  input logic                   rst,
  match_req_dispatcher_if.slave bus
);
  localparam int SLOT_W = slot_w(LAZY_LEN);

  state_t                          state_p1;
  logic                            in_ready_p1;
  logic [LAZY_LEN*NUM_CH-1:0]      pending_p1;
  logic [LAZY_LEN*OFFSET_BITS-1:0] offset_p1;
  logic [LAZY_LEN*INFO_BITS-1:0]   info_p1;
  logic [LAZY_LEN-1:0]             nomatch_p1;

  logic [LAZY_LEN*NUM_CH-1:0]      hit;
  logic [LAZY_LEN-1:0]             nomatch_nxt;
  logic [LAZY_LEN*NUM_CH-1:0]      clr;
  logic [LAZY_LEN*NUM_CH-1:0]      pending_nxt;
  logic [NUM_CH-1:0]               ch_vld;
  logic [NUM_CH*OFFSET_BITS-1:0]   ch_off;
  logic [NUM_CH*INFO_BITS-1:0]     ch_info;
  logic [NUM_CH*SLOT_W-1:0]        ch_slot;
  logic                            accept;

  // ---- stage p0: route compare on the incoming batch ----
  match_req_window_cmp #(
    .LAZY_LEN   (LAZY_LEN),
    .NUM_CH     (NUM_CH),
    .OFFSET_BITS(OFFSET_BITS),
    .ROUTE_MODE (ROUTE_MODE),
    .CH_LO      (CH_LO),
    .CH_HI      (CH_HI)
  ) u_cmp (
    .offset(bus.in_offset),
    .hit   (hit)
  );

  always_comb begin
    nomatch_nxt = '0;
    for (int i = 0; i < LAZY_LEN; i++) nomatch_nxt[i] = ~|hit[i*NUM_CH +: NUM_CH];
  end

  assign accept = (state_p1 == ST_IDLE) && in_ready_p1 && bus.in_valid;

  // ---- stage p1: latched batch, per-channel priority pick ----
  always_comb begin
    ch_vld  = '0;
    ch_off  = '0;
    ch_info = '0;
    ch_slot = '0;
    clr     = '0;
    for (int j = 0; j < NUM_CH; j++) begin
      // Scan high to low so the lowest pending slot is the one left standing.
      for (int i = LAZY_LEN - 1; i >= 0; i--) begin
        if (pending_p1[i*NUM_CH+j]) begin
          ch_vld[j]                          = 1'b1;
          ch_off[j*OFFSET_BITS +: OFFSET_BITS] = offset_p1[i*OFFSET_BITS +: OFFSET_BITS];
          ch_info[j*INFO_BITS +: INFO_BITS]    = info_p1[i*INFO_BITS +: INFO_BITS];
          ch_slot[j*SLOT_W +: SLOT_W]          = SLOT_W'(i);
        end
      end
      for (int i = 0; i < LAZY_LEN; i++) begin
        clr[i*NUM_CH+j] = ch_vld[j] && bus.out_ready[j] && (ch_slot[j*SLOT_W +: SLOT_W] == SLOT_W'(i));
      end
    end
  end

  assign pending_nxt = pending_p1 & ~clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1    <= ST_IDLE;
      in_ready_p1 <= 1'b0;
      pending_p1  <= '0;
    end else begin
      case (state_p1)
        ST_IDLE: begin
          in_ready_p1 <= 1'b1;
          if (accept) begin
            pending_p1  <= hit;
            in_ready_p1 <= 1'b0;
            state_p1    <= (|hit) ? ST_DISPATCH : ST_REPORT;
          end
        end
        ST_DISPATCH: begin
          pending_p1 <= pending_nxt;
          if (pending_nxt == '0) state_p1 <= ST_REPORT;
        end
        ST_REPORT: begin
          in_ready_p1 <= 1'b1;
          state_p1    <= ST_IDLE;
        end
        default: begin
          pending_p1 <= '0;
          state_p1   <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      offset_p1  <= bus.in_offset;
      info_p1    <= bus.in_info;
      nomatch_p1 <= nomatch_nxt;
    end
  end

  assign bus.in_ready     = in_ready_p1;
  assign bus.out_valid    = ch_vld;
  assign bus.out_offset   = ch_off;
  assign bus.out_info     = ch_info;
  assign bus.out_slot     = ch_slot;
  assign bus.done_valid   = (state_p1 == ST_REPORT);
  assign bus.done_nomatch = (state_p1 == ST_REPORT) ? nomatch_p1 : '0;

endmodule

// File: tb/tb_match_req_dispatcher.sv
// Bench for match_req_dispatcher: three instances (multicast defaults,
// lowest-channel routing, and a window set with a coverage hole), driven by a
// vector table plus hand sequences for backpressure and mid-batch reset.
module tb_match_req_dispatcher;
  import match_req_dispatcher_pkg::*;

  localparam logic [83:0] LO_ALT = {21'd131072, 21'd0, 21'd0, 21'd0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc_g = 0;
  always @(posedge clk) cyc_g <= cyc_g + 1;

  logic [2:0]         in_valid_d = '0;
  logic [79:0]        offs       = '0;
  logic [127:0]       infos      = '0;
  logic [3:0]         rdy        = 4'hF;
  logic [2:0]         in_ready_m;
  logic [2:0]         dv_m;
  logic [2:0][3:0]    ov_m;
  logic [2:0][3:0]    dn_m;
  logic [2:0][79:0]   oo_m;
  logic [2:0][127:0]  oi_m;
  logic [2:0][7:0]    os_m;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    match_req_dispatcher_if bus_if ();
    assign bus_if.in_valid  = in_valid_d[g];
    assign bus_if.in_offset = offs;
    assign bus_if.in_info   = infos;
    assign bus_if.out_ready = rdy;
    assign in_ready_m[g]    = bus_if.in_ready;
    assign ov_m[g]          = bus_if.out_valid;
    assign oo_m[g]          = bus_if.out_offset;
    assign oi_m[g]          = bus_if.out_info;
    assign os_m[g]          = bus_if.out_slot;
    assign dv_m[g]          = bus_if.done_valid;
    assign dn_m[g]          = bus_if.done_nomatch;

    match_req_dispatcher #(
      .ROUTE_MODE(g == 1 ? 1 : 0),
      .CH_LO     (g == 2 ? LO_ALT : DEF_CH_LO)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus_if)
    );
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk_i(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  function automatic logic [127:0] mk_info(input logic [79:0] o);
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[i*32 +: 32] = {4'hC, 8'(i + 1), o[i*20 +: 20]};
    return r;
  endfunction

  // Results of the last run_batch call.
  int         r_acc, r_done, r_err_order, r_err_pay, r_err_rdy, r_err_stable, r_stall;
  int         r_last [4];
  logic [3:0] r_mask [4];
  logic [3:0] r_nm;

  // Entered and left just after a rising edge.
  task automatic run_batch(input int d, input logic [79:0] o, input int stall_ch,
                           input int stall_len, input bit chain, input logic [79:0] o_next);
    logic [127:0] inf;
    logic [53:0]  snap, cur;
    bit           snap_ok;
    int           s;
    int           prev [4];
    inf  = mk_info(o);
    offs = o;
    infos = inf;
    in_valid_d[d] = 1'b1;
    rdy = 4'hF;
    if (stall_len > 0) rdy[stall_ch] = 1'b0;
    r_acc = -1; r_done = -1; r_err_order = 0; r_err_pay = 0; r_err_rdy = 0;
    r_err_stable = 0; r_stall = 0; r_nm = '0; snap = '0; snap_ok = 0;
    for (int j = 0; j < 4; j++) begin r_mask[j] = '0; r_last[j] = -1; prev[j] = -1; end
    for (int k = 0; k < 120 && r_done < 0; k++) begin
      @(negedge clk);
      if (r_acc < 0) begin
        if (in_ready_m[d]) r_acc = cyc_g;
      end else begin
        if (in_ready_m[d]) r_err_rdy++;
        for (int j = 0; j < 4; j++) begin
          if (ov_m[d][j] && rdy[j]) begin
            s = int'(os_m[d][j*2 +: 2]);
            if (s <= prev[j]) r_err_order++;
            prev[j] = s;
            r_mask[j][s] = 1'b1;
            r_last[j] = cyc_g;
            if (oo_m[d][j*20 +: 20] !== o[s*20 +: 20]) r_err_pay++;
            if (oi_m[d][j*32 +: 32] !== inf[s*32 +: 32]) r_err_pay++;
            if (j == stall_ch) snap_ok = 0;
          end else if (ov_m[d][j] && !rdy[j] && j == stall_ch && stall_len > 0) begin
            r_stall++;
            cur = {oo_m[d][j*20 +: 20], oi_m[d][j*32 +: 32], os_m[d][j*2 +: 2]};
            if (snap_ok && cur !== snap) r_err_stable++;
            snap = cur;
            snap_ok = 1;
          end
        end
        if (dv_m[d]) begin
          r_done = cyc_g;
          r_nm = dn_m[d];
        end
      end
      @(posedge clk); #1;
      if (r_acc >= 0) begin
        in_valid_d[d] = chain;
        if (chain) begin
          offs = o_next;
          infos = mk_info(o_next);
        end
        if (stall_len > 0 && cyc_g - r_acc > stall_len) rdy[stall_ch] = 1'b1;
      end
    end
    if (!chain) in_valid_d[d] = 1'b0;
  endtask

  task automatic chk_masks(input string tag, input logic [15:0] exp);
    for (int j = 0; j < 4; j++)
      chk_i($sformatf("%s_ch%0d_slots", tag, j), int'(r_mask[j]), int'(exp[j*4 +: 4]));
    chk_i({tag, "_order"}, r_err_order, 0);
    chk_i({tag, "_payload"}, r_err_pay, 0);
    chk_i({tag, "_in_ready_busy"}, r_err_rdy, 0);
  endtask

  typedef struct {
    int          d;
    logic [79:0] o;
    logic [15:0] masks;   // {ch3,ch2,ch1,ch0} slot masks
    logic [3:0]  nm;
    int          lat;     // done cycle - accept cycle
    bit          chain;   // next vector is held on in_valid while this one runs
    bit          b2b;     // accepted the cycle after the previous done pulse
  } vec_t;

  vec_t vecs [7];

  localparam logic [79:0] V_MAIN = {20'd500000, 20'd40000, 20'd20000, 20'd100};

  int  last_done;
  int  dv_cnt;
  bit  acc_seen;

  initial begin
    vecs[0] = '{0, V_MAIN, 16'h8731, 4'h0, 4, 1, 0};
    vecs[1] = '{0, {20'hFFFFF, 20'd65536, 20'd4096, 20'd4095}, 16'hC331, 4'h0, 3, 0, 1};
    vecs[2] = '{1, V_MAIN, 16'h8421, 4'h0, 2, 0, 0};
    vecs[3] = '{1, {20'hFFFFF, 20'd0, 20'd32768, 20'd4096}, 16'h8214, 4'h0, 2, 0, 1};
    vecs[4] = '{2, {20'd1, 20'd1, 20'd70000, 20'd70000}, 16'h0CCC, 4'b0011, 3, 1, 0};
    vecs[5] = '{2, {20'd131071, 20'd65536, 20'd100000, 20'd70000}, 16'h0000, 4'hF, 1, 1, 1};
    vecs[6] = '{2, {20'd131072, 20'd65535, 20'd0, 20'd32767}, 16'h8732, 4'h0, 4, 0, 1};

    // ---- reset state ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_i("rst_in_ready", int'(in_ready_m), 0);
    chk_i("rst_out_valid", int'(ov_m), 0);
    chk_i("rst_done", int'({dv_m, dn_m}), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_i("release_in_ready", int'(in_ready_m), 7);
    @(posedge clk); #1;

    // ---- table ----
    last_done = -1;
    for (int k = 0; k < 7; k++) begin
      run_batch(vecs[k].d, vecs[k].o, 0, 0, vecs[k].chain, (k < 6) ? vecs[k+1].o : 80'd0);
      chk_i($sformatf("v%0d_done_seen", k), (r_done >= 0) ? 1 : 0, 1);
      chk_masks($sformatf("v%0d", k), vecs[k].masks);
      chk_i($sformatf("v%0d_nomatch", k), int'(r_nm), int'(vecs[k].nm));
      chk_i($sformatf("v%0d_latency", k), r_done - r_acc, vecs[k].lat);
      if (vecs[k].b2b) chk_i($sformatf("v%0d_accept_after_done", k), r_acc, last_done + 1);
      last_done = r_done;
    end

    // ---- backpressure: ch2 not ready for 10 cycles ----
    run_batch(0, V_MAIN, 2, 10, 0, 80'd0);
    chk_masks("bp", 16'h8731);
    chk_i("bp_stall_cycles", r_stall, 10);
    chk_i("bp_ch2_stable", r_err_stable, 0);
    chk_i("bp_ch1_drained", r_last[1] - r_acc, 2);
    chk_i("bp_ch3_drained", r_last[3] - r_acc, 1);
    chk_i("bp_done_after_ch2", r_done - r_last[2], 1);
    chk_i("bp_latency", r_done - r_acc, 14);

    // ---- reset in the middle of DISPATCH ----
    rdy = 4'h0;
    offs = V_MAIN;
    infos = mk_info(V_MAIN);
    in_valid_d[0] = 1'b1;
    acc_seen = 0;
    for (int k = 0; k < 20 && !acc_seen; k++) begin
      @(negedge clk);
      if (in_ready_m[0]) acc_seen = 1;
      @(posedge clk); #1;
    end
    in_valid_d[0] = 1'b0;
    chk_i("mr_accepted", int'(acc_seen), 1);
    @(negedge clk);
    chk_i("mr_dispatching", int'(ov_m[0]), 15);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_i("mr_out_valid", int'(ov_m[0]), 0);
    chk_i("mr_done", int'(dv_m[0]), 0);
    chk_i("mr_in_ready_in_reset", int'(in_ready_m[0]), 0);
    @(posedge clk); #1 rst = 1'b0; rdy = 4'hF;
    @(posedge clk);
    @(negedge clk);
    chk_i("mr_in_ready_after", int'(in_ready_m), 7);
    chk_i("mr_out_valid_after", int'(ov_m[0]), 0);
    dv_cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (dv_m[0]) dv_cnt++;
    end
    chk_i("mr_no_done_pulse", dv_cnt, 0);
    @(posedge clk); #1;
    run_batch(0, V_MAIN, 0, 0, 0, 80'd0);
    chk_i("mr_post_done_seen", (r_done >= 0) ? 1 : 0, 1);
    chk_masks("mr_post", 16'h8731);
    chk_i("mr_post_latency", r_done - r_acc, 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
